// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch conditioning stage: channel FSM encoding,
// 50 MHz default timing constants and a saturating increment helper.
package sw_cond_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } sw_state_t;

  localparam int unsigned DEF_DEB_CYC  = 500000;    // 10 ms
  localparam int unsigned DEF_LONG_CYC = 50000000;  // 1 s
  localparam int unsigned DEF_RPT_CYC  = 10000000;  // 200 ms

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sw_cond_ch.sv
// One switch channel: two-flop synchronizer, debounce/hold FSM, and the
// press, long-press and auto-repeat pulse generation.
module sw_cond_ch
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned RPT_CYC  = DEF_RPT_CYC,
  parameter bit          RPT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic press,
  output logic long_press
);

  logic        sync1, sync2;
  logic        s;
  sw_state_t   state, state_next;
  logic [31:0] dcnt, dcnt_next;
  logic [31:0] hcnt, hcnt_next;
  logic [31:0] rcnt, rcnt_next;
  logic [31:0] hcnt_inc, rcnt_inc;

  assign s        = ~sync2;
  assign hcnt_inc = sat_inc(hcnt);
  assign rcnt_inc = sat_inc(rcnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
      rcnt  <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      state <= state_next;
      dcnt  <= dcnt_next;
      hcnt  <= hcnt_next;
      rcnt  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    hcnt_next  = hcnt;
    rcnt_next  = rcnt;
    level      = 1'b0;
    press      = 1'b0;
    long_press = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = DEB_PRESS;
          dcnt_next  = 32'd1;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
        end else if (dcnt == DEB_CYC) begin
          state_next = HELD;
          press      = 1'b1;
          level      = 1'b1;
          hcnt_next  = '0;
          rcnt_next  = '0;
        end else begin
          dcnt_next = sat_inc(dcnt);
        end
      end
      HELD, DEB_REL: begin
        level     = 1'b1;
        hcnt_next = hcnt_inc;
        // rcnt measures the distance from the long pulse / previous repeat
        if (hcnt_inc == LONG_CYC && hcnt != hcnt_inc) begin
          long_press = 1'b1;
          rcnt_next  = '0;
        end else if (hcnt >= LONG_CYC) begin
          if (rcnt_inc == RPT_CYC) begin
            press     = RPT;
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
        if (state == HELD) begin
          if (!s) begin
            state_next = DEB_REL;
            dcnt_next  = 32'd1;
          end
        end else if (s) begin
          state_next = HELD;
        end else if (dcnt == DEB_CYC) begin
          // accepted release: level drops now and no pulse leaves with it
          state_next = IDLE;
          level      = 1'b0;
          press      = 1'b0;
          long_press = 1'b0;
        end else begin
          dcnt_next = sat_inc(dcnt);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/sw_cond.sv
// Switch conditioning top: NUM_SW independent channels turning raw active-low
// buttons into debounced levels, press, long-press and repeat pulses.
module sw_cond
  import sw_cond_pkg::*;
#(
  parameter int unsigned        NUM_SW   = 4,
  parameter int unsigned        DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned        LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned        RPT_CYC  = DEF_RPT_CYC,
  parameter logic [NUM_SW-1:0]  RPT_EN   = 4'b0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_level,
  output logic [NUM_SW-1:0] o_press,
  output logic [NUM_SW-1:0] o_long
);

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_ch
    sw_cond_ch #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC),
      .RPT_CYC  (RPT_CYC),
      .RPT      (RPT_EN[gi])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw         (i_sw[gi]),
      .level      (o_level[gi]),
      .press      (o_press[gi]),
      .long_press (o_long[gi])
    );
  end

endmodule

// File: tb/tb_sw_cond.sv
// Scoreboard bench for sw_cond: stimulus queues expected pulses and level
// samples by absolute cycle; a negedge monitor pops and compares them.
module tb_sw_cond;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_sw;
  logic [3:0] o_level, o_press, o_long;

  sw_cond #(
    .NUM_SW   (4),
    .DEB_CYC  (4),
    .LONG_CYC (20),
    .RPT_CYC  (5),
    .RPT_EN   (4'b0100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sw    (i_sw),
    .o_level (o_level),
    .o_press (o_press),
    .o_long  (o_long)
  );

  typedef struct {int cyc; logic [3:0] p; logic [3:0] l;} ev_t;
  typedef struct {int cyc; int ch; logic v;} lv_t;

  ev_t ev_q[$];
  lv_t lv_q[$];
  ev_t e;
  lv_t lv;
  int  cyc   = 0;
  int  base  = 0;
  int  tests = 0;
  int  fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pulses are popped whenever the DUT shows one, levels on their cycle
  always @(negedge clk) begin
    while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
      e = ev_q.pop_front();
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL pulse_missing cyc=%0d press=0000 long=0000 required cyc=%0d press=%b long=%b",
               cyc, e.cyc, e.p, e.l);
    end
    if ((o_press | o_long) != 4'b0000) begin
      tests = tests + 1;
      if (ev_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL pulse_unexpected cyc=%0d press=%b long=%b required none", cyc, o_press, o_long);
      end else begin
        e = ev_q.pop_front();
        if (e.cyc != cyc || e.p !== o_press || e.l !== o_long) begin
          fails = fails + 1;
          $display("FAIL pulse cyc=%0d press=%b long=%b required cyc=%0d press=%b long=%b",
                   cyc, o_press, o_long, e.cyc, e.p, e.l);
        end else begin
          $display("[TB] pulse ok cyc=%0d press=%b long=%b", cyc, o_press, o_long);
        end
      end
    end
    while (lv_q.size() != 0 && lv_q[0].cyc <= cyc) begin
      lv = lv_q.pop_front();
      tests = tests + 1;
      if (lv.cyc != cyc || o_level[lv.ch] !== lv.v) begin
        fails = fails + 1;
        $display("FAIL level ch=%0d cyc=%0d level=%b required cyc=%0d level=%b",
                 lv.ch, cyc, o_level[lv.ch], lv.cyc, lv.v);
      end else begin
        $display("[TB] level ok ch=%0d cyc=%0d level=%b", lv.ch, cyc, lv.v);
      end
    end
  end

  task automatic start();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int t, input logic [3:0] p, input logic [3:0] l);
    ev_q.push_back('{base + t, p, l});
  endtask

  task automatic lvl(input int t, input int ch, input logic v);
    lv_q.push_back('{base + t, ch, v});
  endtask

  task automatic drained(input string name);
    tests = tests + 1;
    if (ev_q.size() != 0 || lv_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drained_%s pending_pulses=%0d pending_levels=%0d required 0 and 0",
               name, ev_q.size(), lv_q.size());
      ev_q.delete();
      lv_q.delete();
    end else begin
      $display("[TB] scenario %s drained", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_sw  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // reset with all switches held: outputs 0, then one press on every channel
    start();
    for (int c = 0; c < 4; c++) lvl(0, c, 1'b0);
    for (int c = 0; c < 4; c++) lvl(7, c, 1'b1);
    lvl(14, 0, 1'b1);
    for (int c = 0; c < 4; c++) lvl(15, c, 1'b0);
    ev(7, 4'b1111, 4'b0000);
    goto(1);  rst_n = 1'b1;
    goto(9);  i_sw = 4'b1111;
    goto(25); drained("reset");

    // clean short press on sw0
    start();
    i_sw = 4'b1110;
    ev(6, 4'b0001, 4'b0000);
    lvl(5, 0, 1'b0); lvl(6, 0, 1'b1); lvl(15, 0, 1'b1); lvl(16, 0, 1'b0);
    goto(10); i_sw = 4'b1111;
    goto(30); drained("short_sw0");

    // bounce on sw1 then steady press
    start();
    i_sw = 4'b1101;
    ev(14, 4'b0010, 4'b0000);
    lvl(13, 1, 1'b0); lvl(14, 1, 1'b1); lvl(23, 1, 1'b1); lvl(24, 1, 1'b0);
    goto(2);  i_sw = 4'b1111;
    goto(4);  i_sw = 4'b1101;
    goto(6);  i_sw = 4'b1111;
    goto(8);  i_sw = 4'b1101;
    goto(18); i_sw = 4'b1111;
    goto(35); drained("bounce_sw1");

    // long hold on sw2 with auto-repeat
    start();
    i_sw = 4'b1011;
    ev(6, 4'b0100, 4'b0000);
    ev(26, 4'b0000, 4'b0100);
    for (int t = 31; t <= 61; t += 5) ev(t, 4'b0100, 4'b0000);
    lvl(6, 2, 1'b1); lvl(65, 2, 1'b1); lvl(66, 2, 1'b0);
    goto(60); i_sw = 4'b1111;
    goto(80); drained("long_sw2");

    // long hold on sw3, no repeat enabled
    start();
    i_sw = 4'b0111;
    ev(6, 4'b1000, 4'b0000);
    ev(26, 4'b0000, 4'b1000);
    lvl(65, 3, 1'b1); lvl(66, 3, 1'b0);
    goto(60); i_sw = 4'b1111;
    goto(80); drained("long_sw3");

    // release glitch mid-hold on sw0
    start();
    i_sw = 4'b1110;
    ev(6, 4'b0001, 4'b0000);
    lvl(15, 0, 1'b1); lvl(16, 0, 1'b1); lvl(20, 0, 1'b1); lvl(23, 0, 1'b1); lvl(24, 0, 1'b0);
    goto(12); i_sw = 4'b1111;
    goto(14); i_sw = 4'b1110;
    goto(18); i_sw = 4'b1111;
    goto(40); drained("glitch_sw0");

    // asynchronous reset mid-hold, switch still held afterwards
    start();
    i_sw = 4'b0111;
    ev(6, 4'b1000, 4'b0000);
    ev(19, 4'b1000, 4'b0000);
    lvl(9, 3, 1'b1); lvl(10, 3, 1'b0); lvl(18, 3, 1'b0); lvl(19, 3, 1'b1);
    lvl(26, 3, 1'b1); lvl(27, 3, 1'b0);
    goto(10); rst_n = 1'b0;
    goto(13); rst_n = 1'b1;
    goto(21); i_sw = 4'b1111;
    goto(40); drained("reset_mid_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
